// File: rtl/ahb_apb_bridge_pkg.sv
// Shared types and AHB/APB encodings for the AHB-Lite to APB bridge.
package ahb_apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // The APB side is 32 bits wide, so anything wider than a word is refused.
    function automatic logic hsize_legal(input logic [2:0] hsize);
        return hsize <= HSIZE_WORD;
    endfunction

endpackage

// File: rtl/apb_strb_gen.sv
// Byte-lane strobe decode for APB writes; reads and illegal sizes give no lanes.
module apb_strb_gen
    import ahb_apb_bridge_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr,
    input  logic       write,
    output logic [3:0] strb
);

    always_comb begin
        strb = 4'b0000;
        if (write) begin
            case (hsize)
                HSIZE_BYTE: strb = 4'b0001 << addr;
                HSIZE_HALF: strb = 4'b0011 << {addr[1], 1'b0};
                HSIZE_WORD: strb = 4'b1111;
                default:    strb = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite responder to APB initiator bridge: one APB access per AHB transfer,
// OKAY or two-cycle ERROR response, pipelined next address taken in DONE/ERR2.
module ahb_apb_bridge
    import ahb_apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  hclk,
    input  logic                  reset,
    input  logic                  hsels,
    input  logic [ADDR_WIDTH-1:0] haddrs,
    input  logic [1:0]            htranss,
    input  logic [2:0]            hsizes,
    input  logic                  hwrites,
    input  logic                  hreadys,
    input  logic [31:0]           hwdatas,
    output logic                  hreadyouts,
    output logic                  hresps,
    output logic [31:0]           hrdatas,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [3:0]            PSTRB,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [3:0]            r_pstrb;
    logic [31:0]           r_pwdata;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_hreadyout;
    logic                  r_hresp;
    logic [31:0]           r_hrdata;

    logic       w_active_trans;
    logic       w_can_accept;
    logic       w_accept;
    logic [3:0] w_strb;

    assign w_active_trans = (htranss == HTRANS_NONSEQ) || (htranss == HTRANS_SEQ);
    assign w_can_accept   = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR2);
    assign w_accept       = hsels && hreadys && w_active_trans && w_can_accept;

    apb_strb_gen u_strb (
        .hsize (hsizes),
        .addr  (haddrs[1:0]),
        .write (hwrites),
        .strb  (w_strb)
    );

    always_ff @(posedge hclk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pstrb     <= 4'b0000;
            r_pwdata    <= 32'h0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_hrdata    <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    r_state     <= ST_IDLE;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                    if (w_accept) begin
                        r_paddr     <= haddrs;
                        r_pwrite    <= hwrites;
                        r_pstrb     <= w_strb;
                        r_hreadyout <= 1'b0;
                        if (hsize_legal(hsizes)) begin
                            r_state <= ST_SETUP;
                            r_psel  <= 1'b1;
                        end else begin
                            r_state <= ST_ERR1;
                            r_hresp <= HRESP_ERROR;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                    r_pwdata  <= hwdatas;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (PSLVERR) begin
                            r_state <= ST_ERR1;
                            r_hresp <= HRESP_ERROR;
                        end else begin
                            r_state     <= ST_DONE;
                            r_hreadyout <= 1'b1;
                            if (!r_pwrite) r_hrdata <= PRDATA;
                        end
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write data only arrives in the AHB data phase (SETUP), so it is passed
    // through there and held from the register for the rest of the access.
    assign PWDATA     = (r_state == ST_SETUP) ? hwdatas : r_pwdata;
    assign PADDR      = r_paddr;
    assign PSEL       = r_psel;
    assign PENABLE    = r_penable;
    assign PWRITE     = r_pwrite;
    assign PSTRB      = r_pstrb;
    assign hreadyouts = r_hreadyout;
    assign hresps     = r_hresp;
    assign hrdatas    = r_hrdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge: pipelined AHB master, APB responder model.
module tb_ahb_apb_bridge;
    import ahb_apb_bridge_pkg::*;

    localparam int AW = 12;

    logic          hclk = 1'b0;
    logic          reset = 1'b1;
    logic          hsels = 1'b0;
    logic [AW-1:0] haddrs = '0;
    logic [1:0]    htranss = HTRANS_IDLE;
    logic [2:0]    hsizes = 3'd0;
    logic          hwrites = 1'b0;
    logic          hreadys;
    logic [31:0]   hwdatas = 32'h0;
    logic          hreadyouts, hresps;
    logic [31:0]   hrdatas;
    logic [AW-1:0] PADDR;
    logic          PSEL, PENABLE, PWRITE;
    logic [3:0]    PSTRB;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA = 32'h0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    ahb_apb_bridge #(.ADDR_WIDTH(AW)) dut (
        .hclk(hclk), .reset(reset), .hsels(hsels), .haddrs(haddrs), .htranss(htranss),
        .hsizes(hsizes), .hwrites(hwrites), .hreadys(hreadys), .hwdatas(hwdatas),
        .hreadyouts(hreadyouts), .hresps(hresps), .hrdatas(hrdatas),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PSTRB(PSTRB),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    assign hreadys = hreadyouts;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [AW-1:0] addr; logic [2:0] size; logic write; logic [31:0] wdata;
        int waits; logic [31:0] prdata; logic slverr;
    } xfer_t;
    typedef struct {
        logic [AW-1:0] paddr; logic [3:0] pstrb; logic pwrite; logic [31:0] pwdata;
        int waits; logic [31:0] prdata; logic slverr;
    } apb_t;
    typedef struct { logic hresp; int lat; logic rd_ok; logic [31:0] rdata; } rsp_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rdata = 32'h0;
    xfer_t       pend_q[$];
    apb_t        apb_q[$];
    rsp_t        rsp_q[$];
    bit          psel_trace[$];

    function automatic logic [3:0] exp_strb(input logic [2:0] size, input logic [1:0] a,
                                            input logic wr);
        logic [3:0] s;
        int n, base;
        s = 4'b0000;
        if (!wr || size > 3'd2) return s;
        n    = 1 << size;
        base = (int'(a) / n) * n;
        for (int b = 0; b < 4; b++) if (b >= base && b < base + n) s[b] = 1'b1;
        return s;
    endfunction

    task automatic add(input logic [AW-1:0] addr, input logic [2:0] size, input logic wr,
                       input logic [31:0] wdata, input int waits, input logic [31:0] prdata,
                       input logic slverr);
        xfer_t x;
        x = '{addr: addr, size: size, write: wr, wdata: wdata, waits: waits,
              prdata: prdata, slverr: slverr};
        pend_q.push_back(x);
    endtask

    task automatic drive_idle();
        hsels = 1'b0; htranss = HTRANS_IDLE;
    endtask

    // APB responder: checks each access against the expected queue and
    // holds PREADY low for the requested number of wait states.
    apb_t cur;
    apb_t snap;
    int   acc_cyc = 0;
    always @(negedge hclk) begin
        if (reset) begin
            acc_cyc = 0; PREADY = 1'b0; PSLVERR = 1'b0;
        end else if (PSEL && !PENABLE) begin
            tests++;
            if (apb_q.size() == 0) begin
                fails++; $display("FAIL unexpected_psel: PSEL=1 with no APB access expected");
            end
            acc_cyc = 0;
        end else if (PSEL && PENABLE) begin
            if (acc_cyc == 0) begin
                if (apb_q.size() == 0) cur = '{paddr: '0, pstrb: 4'h0, pwrite: 1'b0, pwdata: 32'h0,
                                               waits: 0, prdata: 32'h0, slverr: 1'b0};
                else cur = apb_q.pop_front();
                tests++;
                if (PADDR !== cur.paddr) begin
                    fails++; $display("FAIL paddr: got %h want %h", PADDR, cur.paddr);
                end
                tests++;
                if (PSTRB !== cur.pstrb) begin
                    fails++; $display("FAIL pstrb: got %b want %b (addr %h)", PSTRB, cur.pstrb, cur.paddr);
                end
                tests++;
                if (PWRITE !== cur.pwrite) begin
                    fails++; $display("FAIL pwrite: got %b want %b", PWRITE, cur.pwrite);
                end
                if (cur.pwrite) begin
                    tests++;
                    if (PWDATA !== cur.pwdata) begin
                        fails++; $display("FAIL pwdata: got %h want %h", PWDATA, cur.pwdata);
                    end
                end
                snap = '{paddr: PADDR, pstrb: PSTRB, pwrite: PWRITE, pwdata: PWDATA,
                         waits: 0, prdata: 32'h0, slverr: 1'b0};
            end else begin
                tests++;
                if ({PADDR, PSTRB, PWRITE, PWDATA} !== {snap.paddr, snap.pstrb, snap.pwrite, snap.pwdata}) begin
                    fails++;
                    $display("FAIL apb_stable: got %h/%b/%b/%h want %h/%b/%b/%h", PADDR, PSTRB, PWRITE,
                             PWDATA, snap.paddr, snap.pstrb, snap.pwrite, snap.pwdata);
                end
            end
            PREADY  = (acc_cyc >= cur.waits);
            PSLVERR = PREADY && cur.slverr;
            PRDATA  = PREADY ? cur.prdata : 32'hBAD0_BAD0;
            acc_cyc++;
        end else begin
            acc_cyc = 0; PREADY = 1'b0; PSLVERR = 1'b0;
        end
    end

    // Pipelined AHB master: the next address is presented as soon as the
    // previous one is accepted and held until hreadys is high.
    task automatic run_xfers();
        int    cyc = 0;
        bit    dvalid = 0;
        bit    avalid;
        bit    prev_err = 0;
        int    dlat = 0;
        xfer_t dx, ax;
        rsp_t  r, e;
        apb_t  a;
        while ((pend_q.size() > 0 || dvalid) && cyc < 200) begin
            avalid = pend_q.size() > 0;
            if (avalid) begin
                ax = pend_q[0];
                hsels = 1'b1; htranss = HTRANS_NONSEQ; haddrs = ax.addr;
                hsizes = ax.size; hwrites = ax.write;
            end else drive_idle();
            hwdatas = dvalid ? dx.wdata : 32'h0;
            @(negedge hclk);
            psel_trace.push_back(PSEL);
            if (dvalid) dlat++;
            if (hreadyouts) begin
                if (dvalid) begin
                    e = rsp_q.pop_front();
                    tests++;
                    if (hresps !== e.hresp) begin
                        fails++; $display("FAIL hresp: addr %h got %b want %b", dx.addr, hresps, e.hresp);
                    end
                    tests++;
                    if (dlat != e.lat) begin
                        fails++; $display("FAIL latency: addr %h got %0d want %0d", dx.addr, dlat, e.lat);
                    end
                    if (e.hresp) begin
                        tests++;
                        if (!prev_err) begin
                            fails++; $display("FAIL err_first_cycle: got no hresp=1/hready=0 cycle, want one");
                        end
                    end
                    if (e.rd_ok) last_rdata = e.rdata;
                    tests++;
                    if (hrdatas !== last_rdata) begin
                        fails++; $display("FAIL hrdata: addr %h got %h want %h", dx.addr, hrdatas, last_rdata);
                    end
                end
                dvalid = 0;
                if (avalid) begin
                    void'(pend_q.pop_front());
                    dx = ax; dvalid = 1; dlat = 1; prev_err = 0;
                    r.hresp = (ax.size > 3'd2) || ax.slverr;
                    r.lat   = (ax.size > 3'd2) ? 3 : (ax.slverr ? 5 + ax.waits : 4 + ax.waits);
                    r.rd_ok = (ax.size <= 3'd2) && !ax.slverr && !ax.write;
                    r.rdata = ax.prdata;
                    rsp_q.push_back(r);
                    if (ax.size <= 3'd2) begin
                        a = '{paddr: ax.addr, pstrb: exp_strb(ax.size, ax.addr[1:0], ax.write),
                              pwrite: ax.write, pwdata: ax.wdata, waits: ax.waits,
                              prdata: ax.prdata, slverr: ax.slverr};
                        apb_q.push_back(a);
                    end
                end
            end else if (dvalid) begin
                prev_err = hresps;
            end
            @(posedge hclk); #1;
            cyc++;
        end
        drive_idle();
        tests++;
        if (pend_q.size() > 0 || dvalid) begin
            fails++; $display("FAIL timeout: got %0d pending after %0d cycles, want 0", pend_q.size(), cyc);
            pend_q.delete();
        end
    endtask

    task automatic test_reset();
        hsels = 1'b1; htranss = HTRANS_NONSEQ; haddrs = 12'hABC; hwrites = 1'b1; hsizes = 3'd2;
        @(posedge hclk); #1;
        @(negedge hclk);
        tests++;
        if ({hreadyouts, hresps, PSEL, PENABLE, PWRITE} !== 5'b10000) begin
            fails++; $display("FAIL reset_ctrl: got %b want 10000", {hreadyouts, hresps, PSEL, PENABLE, PWRITE});
        end
        tests++;
        if ({hrdatas, PWDATA} !== 64'h0) begin
            fails++; $display("FAIL reset_data: got %h/%h want 0/0", hrdatas, PWDATA);
        end
        tests++;
        if ({PADDR, PSTRB} !== 16'h0) begin
            fails++; $display("FAIL reset_addr: got %h/%b want 0/0", PADDR, PSTRB);
        end
        @(posedge hclk); #1;
        reset = 1'b0;
        drive_idle();
    endtask

    task automatic test_word_write();
        add(12'h010, 3'd2, 1'b1, 32'hDEADBEEF, 0, 32'h0, 1'b0);
        run_xfers();
    endtask

    task automatic test_strobes();
        add(12'h013, 3'd0, 1'b1, 32'h000000AA, 0, 32'h0, 1'b0);
        add(12'h012, 3'd1, 1'b1, 32'h0000BBBB, 0, 32'h0, 1'b0);
        add(12'h011, 3'd0, 1'b1, 32'h000000CC, 1, 32'h0, 1'b0);
        add(12'h010, 3'd1, 1'b1, 32'h0000DDDD, 0, 32'h0, 1'b0);
        add(12'h008, 3'd2, 1'b0, 32'h0, 0, 32'h0BADF00D, 1'b0);
        run_xfers();
    endtask

    task automatic test_wait_read();
        add(12'h004, 3'd2, 1'b0, 32'h0, 3, 32'h12345678, 1'b0);
        add(12'h020, 3'd2, 1'b1, 32'h01020304, 0, 32'h0, 1'b0);
        add(12'h024, 3'd2, 1'b0, 32'h0, 0, 32'hFFFF0000, 1'b1);
        run_xfers();
    endtask

    task automatic test_slverr();
        add(12'h018, 3'd2, 1'b1, 32'h5A5A5A5A, 1, 32'h0, 1'b1);
        add(12'h01C, 3'd2, 1'b0, 32'h0, 0, 32'hCAFEF00D, 1'b0);
        run_xfers();
    endtask

    task automatic test_back_to_back();
        int exp_tr[7] = '{0, 1, 1, 0, 1, 1, 0};
        psel_trace.delete();
        add(12'h040, 3'd2, 1'b0, 32'h0, 0, 32'h11112222, 1'b0);
        add(12'h044, 3'd2, 1'b0, 32'h0, 0, 32'h33334444, 1'b0);
        run_xfers();
        tests++;
        if (psel_trace.size() != 7) begin
            fails++; $display("FAIL b2b_len: got %0d cycles want 7", psel_trace.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                tests++;
                if (int'(psel_trace[i]) != exp_tr[i]) begin
                    fails++; $display("FAIL b2b_psel[%0d]: got %0d want %0d", i, psel_trace[i], exp_tr[i]);
                end
            end
        end
    endtask

    task automatic test_bad_size();
        psel_trace.delete();
        add(12'h050, 3'd3, 1'b1, 32'h77777777, 0, 32'h0, 1'b0);
        run_xfers();
        foreach (psel_trace[i]) begin
            tests++;
            if (psel_trace[i] !== 1'b0) begin
                fails++; $display("FAIL bad_size_psel[%0d]: got 1 want 0", i);
            end
        end
        add(12'h054, 3'd2, 1'b1, 32'h88888888, 0, 32'h0, 1'b0);
        run_xfers();
    endtask

    task automatic test_idle_busy();
        hsels = 1'b1; htranss = HTRANS_BUSY; haddrs = 12'h0FF; hsizes = 3'd2; hwrites = 1'b1;
        @(negedge hclk);
        tests++;
        if ({hreadyouts, hresps} !== 2'b10) begin
            fails++; $display("FAIL busy_resp: got %b want 10", {hreadyouts, hresps});
        end
        @(posedge hclk); #1;
        htranss = HTRANS_IDLE;
        @(negedge hclk);
        tests++;
        if ({hreadyouts, hresps, PSEL} !== 3'b100) begin
            fails++; $display("FAIL idle_resp: got %b want 100", {hreadyouts, hresps, PSEL});
        end
        @(posedge hclk); #1;
        drive_idle();
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        apb_t a;
        a = '{paddr: 12'h030, pstrb: 4'h0, pwrite: 1'b0, pwdata: 32'h0, waits: 10,
              prdata: 32'h55555555, slverr: 1'b0};
        apb_q.push_back(a);
        hsels = 1'b1; htranss = HTRANS_NONSEQ; haddrs = 12'h030; hsizes = 3'd2; hwrites = 1'b0;
        @(posedge hclk); #1;
        drive_idle();
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge hclk);
            seen = PSEL && PENABLE;
        end
        tests++;
        if (!seen) begin
            fails++; $display("FAIL reset_mid_access: got no ACCESS cycle, want one");
        end
        #2 reset = 1'b1;
        @(negedge hclk);
        tests++;
        if ({PSEL, PENABLE, hreadyouts, hresps} !== 4'b0010) begin
            fails++; $display("FAIL reset_mid_ctrl: got %b want 0010", {PSEL, PENABLE, hreadyouts, hresps});
        end
        tests++;
        if (hrdatas !== 32'h0) begin
            fails++; $display("FAIL reset_mid_hrdata: got %h want 0", hrdatas);
        end
        @(posedge hclk); #1;
        reset = 1'b0;
        apb_q.delete(); rsp_q.delete();
        last_rdata = 32'h0;
        add(12'h034, 3'd2, 1'b0, 32'h0, 0, 32'hA5A50001, 1'b0);
        run_xfers();
    endtask

    initial begin
        repeat (2) @(posedge hclk);
        #1;
        test_reset();
        test_word_write();
        test_strobes();
        test_wait_read();
        test_slverr();
        test_back_to_back();
        test_bad_size();
        test_idle_busy();
        test_reset_mid();
        repeat (2) @(posedge hclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge.md
AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, the width of the forwarded address (haddrs, PADDR).
REQ-002 SHALL have port hclk  in  1  single clock for all logic.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have AHB-Lite responder inputs: hsels 1; haddrs ADDR_WIDTH; htranss 2; hsizes 3; hwrites 1; hreadys 1; hwdatas 32.
REQ-005 SHALL have AHB-Lite responder outputs: hreadyouts 1; hresps 1 (1 = ERROR); hrdatas 32.
REQ-006 SHALL have APB initiator outputs: PADDR ADDR_WIDTH; PSEL 1; PENABLE 1; PWRITE 1; PSTRB 4; PWDATA 32.
REQ-007 SHALL have APB initiator inputs: PRDATA 32; PREADY 1; PSLVERR 1.

Function
REQ-008 SHALL accept an AHB transfer when hsels=1, hreadys=1 and htranss[1]=1 (NONSEQ/SEQ), latching haddrs, hsizes and hwrites; IDLE/BUSY transfers SHALL receive a zero-wait OKAY response.
REQ-009 SHALL implement the states IDLE, SETUP, ACCESS, DONE and ERR1/ERR2.
REQ-010 IDLE -> SETUP on the cycle after acceptance; in SETUP: PSEL=1, PENABLE=0, PWDATA=hwdatas (write data phase), hreadyouts=0.
REQ-011 SETUP -> ACCESS after exactly one cycle; in ACCESS: PSEL=1, PENABLE=1, hreadyouts=0; ACCESS SHALL hold all PADDR/PWRITE/PSTRB/PWDATA values stable while PREADY=0, with no timeout.
REQ-012 ACCESS with PREADY=1 and PSLVERR=0 -> DONE; PRDATA SHALL be registered into hrdatas (reads only); in DONE: PSEL=0, hreadyouts=1, hresps=0.
REQ-013 ACCESS with PREADY=1 and PSLVERR=1 -> ERR1 (hreadyouts=0, hresps=1) -> ERR2 (hreadyouts=1, hresps=1) -> IDLE, forming the two-cycle AHB ERROR response.
REQ-014 A transfer accepted in DONE or ERR2 (the pipelined next address) SHALL go directly to SETUP on the next cycle; otherwise the state returns to IDLE.
REQ-015 A transfer presented during ERR1 (hreadys=0) SHALL NOT be accepted.
REQ-016 Latency from the AHB address phase to hreadyouts=1 SHALL be 4 cycles with zero APB wait states, plus 1 cycle for each cycle PREADY=0.
REQ-017 PSTRB for writes: hsizes=0 gives 4'b0001<<haddrs[1:0]; hsizes=1 gives 4'b0011<<{haddrs[1],1'b0}; hsizes=2 gives 4'b1111. PSTRB SHALL be 4'b0000 for reads.
REQ-018 hsizes>2 SHALL NOT start an APB access; the transfer SHALL go directly to ERR1/ERR2 on the next cycle.
REQ-019 PADDR SHALL equal the latched haddrs, unmodified and not word-aligned.
REQ-020 hrdatas SHALL hold its last value until the next successful read completes.

Reset
REQ-021 While reset=1 on a rising hclk edge, the next state SHALL be: state=IDLE, hreadyouts=1, hresps=0, hrdatas=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PSTRB=0, PWDATA=0.
REQ-022 Reset asserted mid-transfer (SETUP/ACCESS/ERR) SHALL abort the transfer, dropping PSEL on the next edge; no response SHALL be completed.

Structure
REQ-023 A shared package SHALL hold the state enum, the HTRANS constants (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), the HSIZE constants, and the HRESP OKAY/ERROR constants.
REQ-024 Strobe generation SHALL be a separate combinational sub-module, apb_strb_gen (inputs hsize, addr[1:0], write; output strb[3:0]).

Verification
REQ-025 Word write to 0x010, data 0xDEADBEEF, PREADY=1: SETUP then ACCESS with PADDR=0x010, PSTRB=4'hF, PWDATA=0xDEADBEEF; hreadyouts=1 on cycle 4; hresps=0.
REQ-026 Byte write to 0x013: PSTRB=4'b1000; halfword write to 0x012: PSTRB=4'b1100; read: PSTRB=0.
REQ-027 Read from 0x004 with PREADY held low 3 cycles, PRDATA=0x12345678: signals held stable; hreadyouts=1 on cycle 7 with hrdatas=0x12345678.
REQ-028 Write with PSLVERR=1: hresps=1 and hreadyouts=0, then hresps=1 and hreadyouts=1, then IDLE; a NONSEQ presented in ERR2 is accepted and reaches SETUP next cycle.
REQ-029 Back-to-back NONSEQ reads (second address issued in DONE): no IDLE cycle between transfers; PSEL deasserts for exactly one cycle (DONE).
REQ-030 hsizes=3: no PSEL assertion, two-cycle ERROR response; reset pulsed during ACCESS: PSEL=0 and hreadyouts=1 on the next cycle.
